// File: rtl/nn_in_serializer.sv
// Buffers parallel operand words in a small FIFO and streams each one LSB-first
// as a framed bit-serial stream for the nn datapath, with a downstream hold.
module nn_in_serializer #(
   parameter int data_width = 12,
   parameter int fifo_depth = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [data_width-1:0]         in_data,
   input  logic                          in_valid,
   output logic                          in_ready,
   output logic                          nn_in,
   output logic                          nn_valid,
   output logic                          nn_first,
   output logic                          nn_last,
   input  logic                          nn_hold,
   output logic [$clog2(fifo_depth):0]   fifo_count
);

   localparam int AW = $clog2(fifo_depth);
   localparam int CW = $clog2(data_width);
   localparam logic [CW-1:0] LAST_BIT = CW'(data_width - 1);
   localparam logic [AW:0] FULL_COUNT = (AW + 1)'(fifo_depth);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t                state;
   logic [data_width-1:0] mem [fifo_depth];
   logic [AW-1:0]         head;
   logic [AW-1:0]         tail;
   logic [AW:0]           count;
   logic [data_width-1:0] sr;
   logic [CW-1:0]         bit_cnt;

   logic push;
   logic pop;
   logic at_last;

   assign at_last  = (bit_cnt == LAST_BIT);
   assign in_ready = (count != FULL_COUNT);
   assign push     = in_valid & in_ready;
   // A pop only happens when the shifter is free or finishing its last bit, so words never gap.
   assign pop      = !nn_hold && (count != '0) && ((state == IDLE) || at_last);

   assign fifo_count = count;
   assign nn_in      = (state == SHIFT) & sr[0];
   assign nn_valid   = (state == SHIFT) & !nn_hold;
   assign nn_first   = (state == SHIFT) & !nn_hold & (bit_cnt == '0);
   assign nn_last    = (state == SHIFT) & !nn_hold & at_last;

   always_ff @(posedge clk) begin
      if (push) begin
         mem[tail] <= in_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (push) begin
            tail <= tail + 1'b1;
         end
         if (pop) begin
            head <= head + 1'b1;
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Hold freezes the shifter entirely; the FIFO side keeps accepting words.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         sr      <= '0;
         bit_cnt <= '0;
      end else if (!nn_hold) begin
         case (state)
            IDLE: begin
               if (pop) begin
                  sr      <= mem[head];
                  bit_cnt <= '0;
                  state   <= SHIFT;
               end
            end
            SHIFT: begin
               if (!at_last) begin
                  sr      <= sr >> 1;
                  bit_cnt <= bit_cnt + 1'b1;
               end else if (pop) begin
                  sr      <= mem[head];
                  bit_cnt <= '0;
               end else begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
